// File: rtl/clock_rate_monitor_pkg.sv
// Shared types and constants for the clock rate monitor: FSM state encoding
// and the saturating error counter width.
package clock_rate_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } crm_state_e;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/clock_rate_monitor_if.sv
// Monitored-clock input, error clear and status outputs of the rate monitor.
interface clock_rate_monitor_if #(
  parameter int CNT_W = 4
);
  import clock_rate_monitor_pkg::*;

  logic             clk_div;
  logic             err_clr;
  logic             rise_stb;
  logic             locked;
  logic             period_err;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] measured_period;

  modport master (
    output clk_div,
    output err_clr,
    input  rise_stb,
    input  locked,
    input  period_err,
    input  err_count,
    input  measured_period
  );

  modport slave (
    input  clk_div,
    input  err_clr,
    output rise_stb,
    output locked,
    output period_err,
    output err_count,
    output measured_period
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clock_rate_monitor.sv
// Measures the period and duty of a divided clock in clkin cycles, locks after
// LOCK_COUNT good periods and flags period, duty and loss-of-clock errors.
//
// state    | meaning
// IDLE     | no edge seen yet, or monitored clock lost (timeout)
// ACQUIRE  | counting consecutive good periods towards lock
// LOCKED   | rate matches DIV; a bad period or timeout is an error
module clock_rate_monitor
  import clock_rate_monitor_pkg::*;
#(
  parameter int DIV        = 3,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 4 * DIV
) (
  input logic                 clkin,
  input logic                 reset,
  clock_rate_monitor_if.slave mon
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  DIV_C     = CNT_W'(DIV);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  HI_FLOOR  = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0]  HI_CEIL   = CNT_W'((DIV + 1) / 2);
  localparam logic [GOOD_W-1:0] LOCK_M1   = GOOD_W'(LOCK_COUNT - 1);

  logic             sync_lvl;
  logic             rise;
  logic             edge_q;
  logic             rise_q;
  logic             rise_stb_q;

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] meas_q, meas_d;

  crm_state_e       state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic             locked_q;

  logic             perr_q, perr_d;
  logic [ERR_W-1:0] errc_q, errc_d;

  logic             period_good;
  logic             timeout;
  logic             err_evt;

  sync_2ff u_sync (
    .clk   (clkin),
    .rst_n (reset),
    .d_i   (mon.clk_div),
    .q_o   (sync_lvl)
  );

  assign rise = sync_lvl & ~edge_q;

  // rise_q and edge_q are cycle-aligned: edge_q is the level belonging to rise_q
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      edge_q     <= 1'b0;
      rise_q     <= 1'b0;
      rise_stb_q <= 1'b0;
    end else begin
      edge_q     <= sync_lvl;
      rise_q     <= rise;
      rise_stb_q <= rise_q;
    end
  end

  always_comb begin
    per_d  = per_q;
    hi_d   = hi_q;
    meas_d = meas_q;
    if (rise_q) begin
      meas_d = per_q;
      per_d  = CNT_W'(1);
      hi_d   = CNT_W'(1);
    end else begin
      if (per_q != TIMEOUT_C) begin
        per_d = per_q + 1'b1;
      end
      if (edge_q && (hi_q != TIMEOUT_C)) begin
        hi_d = hi_q + 1'b1;
      end
    end
  end

  assign period_good = (per_q == DIV_C) && ((hi_q == HI_FLOOR) || (hi_q == HI_CEIL));
  assign timeout     = (per_q == TIMEOUT_C) && !rise_q;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (rise_q) begin
          if (!period_good) begin
            good_d = '0;
          end else if (good_q == LOCK_M1) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (rise_q && !period_good) begin
          err_evt = 1'b1;
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase
    if (timeout) begin
      err_evt = (state_q == ST_LOCKED);
      state_d = ST_IDLE;
      good_d  = '0;
    end
  end

  // A new error takes priority over a simultaneous clear
  always_comb begin
    perr_d = perr_q;
    errc_d = errc_q;
    if (err_evt) begin
      perr_d = 1'b1;
      errc_d = mon.err_clr ? ERR_W'(1) : err_sat_inc(errc_q);
    end else if (mon.err_clr) begin
      perr_d = 1'b0;
      errc_d = '0;
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      per_q    <= '0;
      hi_q     <= '0;
      meas_q   <= '0;
      state_q  <= ST_IDLE;
      good_q   <= '0;
      locked_q <= 1'b0;
      perr_q   <= 1'b0;
      errc_q   <= '0;
    end else begin
      per_q    <= per_d;
      hi_q     <= hi_d;
      meas_q   <= meas_d;
      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= (state_q == ST_LOCKED);
      perr_q   <= perr_d;
      errc_q   <= errc_d;
    end
  end

  assign mon.rise_stb        = rise_stb_q;
  assign mon.locked          = locked_q;
  assign mon.period_err      = perr_q;
  assign mon.err_count       = errc_q;
  assign mon.measured_period = meas_q;

endmodule
